// File: rtl/pipe_reg_pkg.sv
// Shared types and constants for the pipe_reg_skid two-entry skid buffer.
package pipe_reg_pkg;

  localparam int PIPE_REG_DEFAULT_WIDTH = 16;

  // Buffer fill state: main register only, or main plus skid register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/pipe_reg_word.sv
// One data word register with load enable and async active-low reset to RESET_VALUE.
module pipe_reg_word #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_reg_skid.sv
// Two-entry skid-buffer pipeline register; ready/valid both decoded from registered state.
// Optional synchronous flush port enabled by defining PIPE_REG_FLUSH_EN.
module pipe_reg_skid
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH       = PIPE_REG_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             Clk,
  input  logic             reset,
`ifdef PIPE_REG_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  state_t           state_reg;
  state_t           state_next;
  logic             in_fire;
  logic             out_fire;
  logic             flush_req;
  logic             main_load;
  logic             main_from_skid;
  logic             skid_load;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

`ifdef PIPE_REG_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;

  always_comb begin
    state_next     = state_reg;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (in_fire) begin
          main_load  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load  = 1'b1;
          state_next = FULL;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_next     = BUSY;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Flush drops the held words by state only; data registers keep their contents.
    if (flush_req) begin
      state_next = EMPTY;
      main_load  = 1'b0;
      skid_load  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_reg_word #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main (
    .Clk   (Clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_reg_word #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skid (
    .Clk   (Clk),
    .reset (reset),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_q)
  );

  always_comb begin
    case (state_reg)
      EMPTY:   occupancy = OCC_EMPTY;
      BUSY:    occupancy = OCC_BUSY;
      FULL:    occupancy = OCC_FULL;
      default: occupancy = OCC_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed bench for pipe_reg_skid: a 16-bit default instance and a 32-bit DEADBEEF-reset
// instance driven in lockstep; flush checks compile only with PIPE_REG_FLUSH_EN.
module tb_pipe_reg_skid;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic        a_in_ready, a_out_valid;
  logic [15:0] a_out_data;
  logic [1:0]  a_occ;
  logic [31:0] b_in_data;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [1:0]  b_occ;

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [31:0] wide(input logic [15:0] x);
    return {x, x ^ 16'h5A5A};
  endfunction

  assign b_in_data = wide(in_data);

  pipe_reg_skid dut16 (
    .Clk       (clk),
    .reset     (reset),
`ifdef PIPE_REG_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .in_data   (in_data),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .out_data  (a_out_data),
    .occupancy (a_occ)
  );

  pipe_reg_skid #(
    .WIDTH       (32),
    .RESET_VALUE (32'hDEADBEEF)
  ) dut32 (
    .Clk       (clk),
    .reset     (reset),
`ifdef PIPE_REG_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .out_data  (b_out_data),
    .occupancy (b_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_full();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hAAAA;
    tick();
    in_data   = 16'hBBBB;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 16'h0000;
    #12;
    check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, a_in_ready},  32'd1);
    check("rst_occ",       {30'd0, a_occ},       32'd0);
    check("rst_data16",    {16'd0, a_out_data},  32'd0);
    check("rst_data32",    b_out_data,           32'hDEADBEEF);
    check("rst_occ32",     {30'd0, b_occ},       32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Single word, one-cycle latency
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_valid", {31'd0, a_out_valid}, 32'd1);
    check("single_data",  {16'd0, a_out_data},  32'h1234);
    check("single_occ",   {30'd0, a_occ},       32'd1);
    tick();
    check("single_drain", {31'd0, a_out_valid}, 32'd0);

    // Full-rate stream
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      check($sformatf("stream_ready%0d", i), {31'd0, a_in_ready}, 32'd1);
      tick();
      check($sformatf("stream_valid%0d", i), {31'd0, a_out_valid}, 32'd1);
      check($sformatf("stream_data%0d", i),  {16'd0, a_out_data},  32'(i));
      check($sformatf("stream_occ%0d", i),   {30'd0, a_occ},       32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain", {31'd0, a_out_valid}, 32'd0);

    // Backpressure into FULL, then drain in order
    fill_full();
    check("bp_occ",      {30'd0, a_occ},      32'd2);
    check("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
    check("bp_data",     {16'd0, a_out_data}, 32'h0000AAAA);
    check("bp_occ32",    {30'd0, b_occ},      32'd2);
    check("bp_data32",   b_out_data,          wide(16'hAAAA));
    in_valid = 1'b1;
    in_data  = 16'hDDDD;
    tick();
    in_valid = 1'b0;
    check("bp_hold_data", {16'd0, a_out_data}, 32'h0000AAAA);
    check("bp_hold_occ",  {30'd0, a_occ},      32'd2);
    out_ready = 1'b1;
    tick();
    check("bp_drain1",   {16'd0, a_out_data}, 32'h0000BBBB);
    check("bp_drain1_32", b_out_data,         wide(16'hBBBB));
    check("bp_occ1",     {30'd0, a_occ},      32'd1);
    tick();
    check("bp_drain2",   {31'd0, a_out_valid}, 32'd0);
    check("bp_drain2_32", {31'd0, b_out_valid}, 32'd0);

    // Asynchronous reset while FULL
    fill_full();
    #3;
    reset = 1'b0;
    #1;
    check("async_valid",  {31'd0, a_out_valid}, 32'd0);
    check("async_ready",  {31'd0, a_in_ready},  32'd1);
    check("async_occ",    {30'd0, a_occ},       32'd0);
    check("async_data",   {16'd0, a_out_data},  32'd0);
    check("async_data32", b_out_data,           32'hDEADBEEF);
    #1;
    reset = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h5555;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("post_rst_data", {16'd0, a_out_data}, 32'h00005555);
    check("post_rst_occ",  {30'd0, a_occ},      32'd1);
    out_ready = 1'b1;
    tick();
    check("post_rst_drain", {31'd0, a_out_valid}, 32'd0);

`ifdef PIPE_REG_FLUSH_EN
    fill_full();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hCCCC;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_occ",   {30'd0, a_occ},       32'd0);
    check("flush_valid", {31'd0, a_out_valid}, 32'd0);
    check("flush_data",  {16'd0, a_out_data},  32'h0000AAAA);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_no_cccc", {31'd0, a_out_valid}, 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
